// File: rtl/wb_mtimer.sv
// -----------------------------------------------------------------------------
// wb_mtimer
//   Wishbone classic slave timer. It provides a 64-bit free-running mtime
//   counter, a 64-bit mtimecmp compare register and a level timer interrupt.
//   A read of MTIME_LO loads a snapshot of mtime[63:32] into a shadow register.
//   MTIME_HI reads return that shadow, so a LO-then-HI read pair sees one
//   coherent 64-bit value.
//
//   Optional feature macro: WB_MTIMER_PRESCALER_EN
//     defined   : CTRL[15:8] PRE is stored. An 8-bit down-counter produces
//                 one tick every PRE+1 cycles while EN=1.
//     undefined : every cycle with EN=1 is a tick. CTRL[15:8] reads 0.
//
// Parameters
//   AW        byte address width. The word address is [AW-1:2]. Only bits
//             [4:2] are decoded, so the map aliases across the upper bits.
//
// Ports
//   i_clk     clock
//   i_rst     asynchronous active-high reset (asserts immediately,
//             releases synchronously to i_clk)
//   i_wb_adr  word address [AW-1:2]
//   i_wb_dat  write data
//   i_wb_sel  byte enables
//   i_wb_we   write enable
//   i_wb_cyc  bus cycle
//   i_wb_stb  strobe
//   o_wb_rdt  read data, registered with the response
//   o_wb_ack  transfer acknowledge (mapped offsets), one-cycle pulse
//   o_wb_err  error response (unmapped offsets 0x18/0x1C), one-cycle pulse
//   o_irq     level timer interrupt = IRQ_EN & (mtime >= mtimecmp), registered
//
// Register map (byte offset)
//   0x00 MTIME_LO     rw
//   0x04 MTIME_HI     rw (reads return the shadow)
//   0x08 MTIMECMP_LO  rw
//   0x0C MTIMECMP_HI  rw
//   0x10 CTRL         rw  [0] EN, [1] IRQ_EN, [15:8] PRE
//   0x14 STATUS       ro  [0] PEND
// -----------------------------------------------------------------------------
module wb_mtimer #(
  parameter int AW = 12
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [AW-3:0] i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic          o_wb_err,
  output logic          o_irq
);

  localparam logic [2:0] OFF_MTIME_LO = 3'd0;
  localparam logic [2:0] OFF_MTIME_HI = 3'd1;
  localparam logic [2:0] OFF_CMP_LO   = 3'd2;
  localparam logic [2:0] OFF_CMP_HI   = 3'd3;
  localparam logic [2:0] OFF_CTRL     = 3'd4;
  localparam logic [2:0] OFF_STATUS   = 3'd5;

  // Replace the bytes of old_v selected by sel_v with the matching bytes of new_v.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel_v);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel_v[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Reset conditioning. Assertion is immediate. Release is retimed to i_clk,
  // so every state register leaves reset on the same edge.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       rst_s;

  // Two-stage reset release synchroniser.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

  assign rst_s = rst_sync_q[1];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [63:0] mtime_q,     mtime_d;
  logic [63:0] mtimecmp_q,  mtimecmp_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic        en_q,        en_d;
  logic        irq_en_q,    irq_en_d;
  logic        ack_q,       ack_d;
  logic        err_q,       err_d;
  logic [31:0] rdt_q,       rdt_d;
  logic        irq_q,       irq_d;
`ifdef WB_MTIMER_PRESCALER_EN
  logic [7:0]  pre_q,       pre_d;
  logic [7:0]  cnt_q,       cnt_d;
`endif

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic [2:0]  off_s;
  logic        req_s;
  logic        mapped_s;
  logic        wr_s;
  logic        rd_s;
  logic        mtime_wr_s;
  logic        ctrl_wr_en_s;
  logic        pend_s;
  logic        tick_s;
  logic [31:0] ctrl_rd_s;
  logic [31:0] ctrl_wr_s;
  logic [31:0] rd_mux_s;
  logic        unused_s;

  assign off_s    = i_wb_adr[2:0];
  // Excluding an already-issued response keeps a still-high stb from being
  // answered twice.
  assign req_s    = i_wb_cyc & i_wb_stb & ~ack_q & ~err_q;
  assign mapped_s = (off_s != 3'd6) && (off_s != 3'd7);
  assign wr_s     = req_s & i_wb_we & mapped_s;
  assign rd_s     = req_s & ~i_wb_we;

  assign mtime_wr_s   = wr_s & ((off_s == OFF_MTIME_LO) | (off_s == OFF_MTIME_HI));
  assign ctrl_wr_en_s = wr_s & (off_s == OFF_CTRL);

  assign pend_s = (mtime_q >= mtimecmp_q);

`ifdef WB_MTIMER_PRESCALER_EN
  assign ctrl_rd_s = {16'h0000, pre_q, 6'b000000, irq_en_q, en_q};
  assign tick_s    = en_q & (cnt_q == 8'd0);
`else
  assign ctrl_rd_s = {30'h0000_0000, irq_en_q, en_q};
  assign tick_s    = en_q;
`endif

  assign ctrl_wr_s = merge_bytes(ctrl_rd_s, i_wb_dat, i_wb_sel);

  // Upper address bits alias, and reserved CTRL bits are write-ignored.
`ifdef WB_MTIMER_PRESCALER_EN
  assign unused_s = ^{i_wb_adr[AW-3:3], ctrl_wr_s[31:16], ctrl_wr_s[7:2]};
`else
  assign unused_s = ^{i_wb_adr[AW-3:3], ctrl_wr_s[31:2]};
`endif

  // Read data multiplexer for the addressed register.
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (off_s)
      OFF_MTIME_LO: rd_mux_s = mtime_q[31:0];
      OFF_MTIME_HI: rd_mux_s = hi_shadow_q;
      OFF_CMP_LO:   rd_mux_s = mtimecmp_q[31:0];
      OFF_CMP_HI:   rd_mux_s = mtimecmp_q[63:32];
      OFF_CTRL:     rd_mux_s = ctrl_rd_s;
      OFF_STATUS:   rd_mux_s = {31'h0000_0000, pend_s};
      default:      rd_mux_s = 32'h0000_0000;
    endcase
  end

  // mtime next state. A software write replaces this cycle's increment:
  // written bytes take the bus data, all other bits keep the current value.
  always_comb begin
    mtime_d = mtime_q;
    if (mtime_wr_s) begin
      case (off_s)
        OFF_MTIME_LO: mtime_d = {mtime_q[63:32],
                                 merge_bytes(mtime_q[31:0], i_wb_dat, i_wb_sel)};
        OFF_MTIME_HI: mtime_d = {merge_bytes(mtime_q[63:32], i_wb_dat, i_wb_sel),
                                 mtime_q[31:0]};
        default:      mtime_d = mtime_q;
      endcase
    end else if (tick_s) begin
      mtime_d = mtime_q + 64'd1;
    end else begin
      mtime_d = mtime_q;
    end
  end

  // mtimecmp and CTRL next state. STATUS writes are acknowledged and dropped.
  always_comb begin
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    irq_en_d   = irq_en_q;
`ifdef WB_MTIMER_PRESCALER_EN
    pre_d      = pre_q;
`endif
    if (wr_s) begin
      case (off_s)
        OFF_CMP_LO: mtimecmp_d = {mtimecmp_q[63:32],
                                  merge_bytes(mtimecmp_q[31:0], i_wb_dat, i_wb_sel)};
        OFF_CMP_HI: mtimecmp_d = {merge_bytes(mtimecmp_q[63:32], i_wb_dat, i_wb_sel),
                                  mtimecmp_q[31:0]};
        OFF_CTRL: begin
          en_d     = ctrl_wr_s[0];
          irq_en_d = ctrl_wr_s[1];
`ifdef WB_MTIMER_PRESCALER_EN
          pre_d    = ctrl_wr_s[15:8];
`endif
        end
        default: mtimecmp_d = mtimecmp_q;
      endcase
    end else begin
      mtimecmp_d = mtimecmp_q;
    end
  end

`ifdef WB_MTIMER_PRESCALER_EN
  // Prescaler down-counter. A CTRL write reloads it with the new PRE, and it
  // stays parked at PRE while counting is disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (ctrl_wr_en_s) begin
      cnt_d = pre_d;
    end else if (!en_q) begin
      cnt_d = pre_q;
    end else if (cnt_q == 8'd0) begin
      cnt_d = pre_q;
    end else begin
      cnt_d = cnt_q - 8'd1;
    end
  end
`else
  // No prescaler: the CTRL write strobe has no consumer.
  always_comb begin
    if (ctrl_wr_en_s) begin
    end else begin
    end
  end
`endif

  // Bus response, read data, shadow capture and interrupt next state.
  always_comb begin
    ack_d       = req_s & mapped_s;
    err_d       = req_s & ~mapped_s;
    rdt_d       = rdt_q;
    hi_shadow_d = hi_shadow_q;
    irq_d       = irq_en_q & pend_s;
    if (rd_s) begin
      // rd_mux_s is 0 for unmapped offsets, so an err read returns 0.
      rdt_d = rd_mux_s;
      if (off_s == OFF_MTIME_LO) begin
        hi_shadow_d = mtime_q[63:32];
      end else begin
        hi_shadow_d = hi_shadow_q;
      end
    end else begin
      rdt_d       = rdt_q;
      hi_shadow_d = hi_shadow_q;
    end
  end

  // State registers.
  always_ff @(posedge i_clk or posedge rst_s) begin
    if (rst_s) begin
      mtime_q     <= 64'h0000_0000_0000_0000;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      hi_shadow_q <= 32'h0000_0000;
      en_q        <= 1'b0;
      irq_en_q    <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rdt_q       <= 32'h0000_0000;
      irq_q       <= 1'b0;
`ifdef WB_MTIMER_PRESCALER_EN
      pre_q       <= 8'h00;
      cnt_q       <= 8'h00;
`endif
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      hi_shadow_q <= hi_shadow_d;
      en_q        <= en_d;
      irq_en_q    <= irq_en_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdt_q       <= rdt_d;
      irq_q       <= irq_d;
`ifdef WB_MTIMER_PRESCALER_EN
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign o_wb_rdt = rdt_q;
  assign o_wb_ack = ack_q;
  assign o_wb_err = err_q;
  assign o_irq    = irq_q;

endmodule

// File: tb/tb_wb_mtimer.sv
// -----------------------------------------------------------------------------
// tb_wb_mtimer
//   Directed self-checking bench for wb_mtimer. Each bus transfer pushes its
//   expected response (ack/err, read data) into a scoreboard queue when it is
//   driven. The entry is popped and compared when the DUT responds.
//   Counter values are predicted from the bench cycle count:
//     mtime seen by a request at edge tR = base + (tR - 1 - tB),
//   where tB is the edge of the CTRL write that started counting.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_mtimer;
  localparam int AW = 12;

  localparam logic [AW-3:0] W_LO   = 10'd0;
  localparam logic [AW-3:0] W_HI   = 10'd1;
  localparam logic [AW-3:0] W_CLO  = 10'd2;
  localparam logic [AW-3:0] W_CHI  = 10'd3;
  localparam logic [AW-3:0] W_CTRL = 10'd4;
  localparam logic [AW-3:0] W_STAT = 10'd5;
  localparam logic [AW-3:0] W_UN6  = 10'd6;
  localparam logic [AW-3:0] W_UN7  = 10'd7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-3:0] wb_adr = '0;
  logic [31:0]   wb_dat = 32'h0;
  logic [3:0]    wb_sel = 4'h0;
  logic          wb_we  = 1'b0;
  logic          wb_cyc = 1'b0;
  logic          wb_stb = 1'b0;
  logic [31:0]   wb_rdt;
  logic          wb_ack;
  logic          wb_err;
  logic          irq;

  wb_mtimer #(.AW(AW)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_wb_adr (wb_adr),
    .i_wb_dat (wb_dat),
    .i_wb_sel (wb_sel),
    .i_wb_we  (wb_we),
    .i_wb_cyc (wb_cyc),
    .i_wb_stb (wb_stb),
    .o_wb_rdt (wb_rdt),
    .o_wb_ack (wb_ack),
    .o_wb_err (wb_err),
    .o_irq    (irq)
  );

  always #5 clk = ~clk;

  int unsigned cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        err;
    logic [31:0] rdt;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_rd = 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One Wishbone classic transfer, entered and left on a falling edge.
  task automatic xfer(input string tag, input logic we, input logic [AW-3:0] wadr,
                      input logic [31:0] wdat, input logic [3:0] sel,
                      input logic [31:0] exp_rd);
    exp_t e;
    int   n;
    bit   got;
    e.err = (wadr[2:0] >= 3'd6);
    if (we) begin
      e.rdt = last_rd;
    end else begin
      e.rdt   = e.err ? 32'h0 : exp_rd;
      last_rd = e.rdt;
    end
    sb_q.push_back(e);
    wb_adr = wadr; wb_dat = wdat; wb_sel = sel; wb_we = we;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      got = wb_ack | wb_err;
    end
    e = sb_q.pop_front();
    chk({tag, ".resp"}, got, 1);
    if (got) begin
      chk({tag, ".lat"}, n, 1);
      chk({tag, ".ack"}, wb_ack, !e.err);
      chk({tag, ".err"}, wb_err, e.err);
      chk({tag, ".rdt"}, wb_rdt, e.rdt);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    chk({tag, ".pulse"}, {wb_ack, wb_err}, 0);
  endtask

  function automatic logic [63:0] cnt_at(input logic [63:0] base, input int unsigned tb,
                                         input int unsigned tr);
    return base + 64'(tr - 1 - tb);
  endfunction

  function automatic logic [63:0] ps_at(input int unsigned tb, input int unsigned tr);
`ifdef WB_MTIMER_PRESCALER_EN
    return 64'((tr - 1 - tb) / 4);
`else
    return 64'(tr - 1 - tb);
`endif
  endfunction

  initial begin
    int unsigned tb_s, tw, tr;
    logic [63:0] v, nv;
    logic [31:0] ctrl_exp;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.ack", wb_ack, 0);
    chk("rst.err", wb_err, 0);
    chk("rst.irq", irq, 0);
    chk("rst.rdt", wb_rdt, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    xfer("r0.lo",   1'b0, W_LO,   32'h0, 4'hF, 32'h0000_0000);
    xfer("r0.hi",   1'b0, W_HI,   32'h0, 4'hF, 32'h0000_0000);
    xfer("r0.clo",  1'b0, W_CLO,  32'h0, 4'hF, 32'hFFFF_FFFF);
    xfer("r0.chi",  1'b0, W_CHI,  32'h0, 4'hF, 32'hFFFF_FFFF);
    xfer("r0.ctrl", 1'b0, W_CTRL, 32'h0, 4'hF, 32'h0000_0000);
    xfer("r0.stat", 1'b0, W_STAT, 32'h0, 4'hF, 32'h0000_0000);
    chk("r0.irq", irq, 0);

    // Carry into the high word, with a coherent shadow
    xfer("c.wlo",  1'b1, W_LO,   32'hFFFF_FFFE, 4'hF, 32'h0);
    xfer("c.whi",  1'b1, W_HI,   32'h0, 4'hF, 32'h0);
    tb_s = cycle + 1;
    xfer("c.en",   1'b1, W_CTRL, 32'h1, 4'hF, 32'h0);
    tr = cycle + 1;
    v  = cnt_at(64'h0000_0000_FFFF_FFFE, tb_s, tr);
    xfer("c.rlo1", 1'b0, W_LO, 32'h0, 4'hF, v[31:0]);
    xfer("c.rhi1", 1'b0, W_HI, 32'h0, 4'hF, v[63:32]);
    repeat (3) @(negedge clk);
    tr = cycle + 1;
    v  = cnt_at(64'h0000_0000_FFFF_FFFE, tb_s, tr);
    xfer("c.rlo2", 1'b0, W_LO, 32'h0, 4'hF, v[31:0]);
    xfer("c.rhi2", 1'b0, W_HI, 32'h0, 4'hF, v[63:32]);
    chk("c.hi_is_1", v[63:32], 64'h1);

    // Compare and interrupt
    xfer("i.stop", 1'b1, W_CTRL, 32'h0,  4'hF, 32'h0);
    xfer("i.clo",  1'b1, W_CLO,  32'h20, 4'hF, 32'h0);
    xfer("i.chi",  1'b1, W_CHI,  32'h0,  4'hF, 32'h0);
    xfer("i.wlo",  1'b1, W_LO,   32'h0,  4'hF, 32'h0);
    xfer("i.whi",  1'b1, W_HI,   32'h0,  4'hF, 32'h0);
    xfer("i.st0",  1'b0, W_STAT, 32'h0,  4'hF, 32'h0);
    tb_s = cycle + 1;
    xfer("i.en",   1'b1, W_CTRL, 32'h3,  4'hF, 32'h0);
    while (cycle < tb_s + 31) @(negedge clk);
    chk("i.irq_m31", irq, 0);
    @(negedge clk);
    chk("i.irq_at20", irq, 0);
    @(negedge clk);
    chk("i.irq_rise", irq, 1);
    xfer("i.st1",  1'b0, W_STAT, 32'h0, 4'hF, 32'h1);
    chk("i.irq_hold", irq, 1);
    xfer("i.chi1", 1'b1, W_CHI,  32'h1, 4'hF, 32'h0);
    chk("i.irq_drop", irq, 0);

    // Byte-lane write into a running counter
    tw = cycle + 1;
    v  = 64'(tw - 1 - tb_s);
    nv = (v & ~64'h0000_FF00) | 64'h0000_AB00;
    xfer("b.w",   1'b1, W_LO, 32'h0000_AB00, 4'b0010, 32'h0);
    tr = cycle + 1;
    xfer("b.rlo", 1'b0, W_LO, 32'h0, 4'hF, 32'(nv + 64'(tr - 1 - tw)));

    // STATUS write, sel=0 write, address aliasing
    xfer("s.wst",  1'b1, W_STAT, 32'hFFFF_FFFF, 4'hF, 32'h0);
    xfer("s.ctrl", 1'b0, W_CTRL, 32'h0, 4'hF, 32'h3);
    xfer("s.sel0", 1'b1, W_CLO,  32'hDEAD_BEEF, 4'h0, 32'h0);
    xfer("s.alias", 1'b0, 10'h342, 32'h0, 4'hF, 32'h20);

    // Unmapped offsets
    xfer("u.r18",  1'b0, W_UN6,  32'h0, 4'hF, 32'h0);
    xfer("u.w1c",  1'b1, W_UN7,  32'h1234_5678, 4'hF, 32'h0);
    xfer("u.w18",  1'b1, W_UN6,  32'h0, 4'hF, 32'h0);
    xfer("u.clo",  1'b0, W_CLO,  32'h0, 4'hF, 32'h20);
    xfer("u.chi",  1'b0, W_CHI,  32'h0, 4'hF, 32'h1);
    xfer("u.ctrl", 1'b0, W_CTRL, 32'h0, 4'hF, 32'h3);

    // Reset with a request outstanding
    xfer("x.chi0", 1'b1, W_CHI, 32'h0, 4'hF, 32'h0);
    chk("x.irq_pre", irq, 1);
    wb_adr = W_LO; wb_we = 1'b0; wb_sel = 4'hF; wb_cyc = 1'b1; wb_stb = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("x.irq_rst", irq, 0);
    chk("x.rdt_rst", wb_rdt, 0);
    @(negedge clk);
    chk("x.ack_rst", {wb_ack, wb_err}, 0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    rst = 1'b0;
    last_rd = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("x.quiet", {wb_ack, wb_err}, 0);
    end
    xfer("x.lo",   1'b0, W_LO,   32'h0, 4'hF, 32'h0);
    xfer("x.hi",   1'b0, W_HI,   32'h0, 4'hF, 32'h0);
    xfer("x.clo",  1'b0, W_CLO,  32'h0, 4'hF, 32'hFFFF_FFFF);
    xfer("x.ctrl", 1'b0, W_CTRL, 32'h0, 4'hF, 32'h0);

    // 64-bit wrap
    xfer("w.wlo", 1'b1, W_LO, 32'hFFFF_FFFF, 4'hF, 32'h0);
    xfer("w.whi", 1'b1, W_HI, 32'hFFFF_FFFF, 4'hF, 32'h0);
    tb_s = cycle + 1;
    xfer("w.en",  1'b1, W_CTRL, 32'h1, 4'hF, 32'h0);
    tr = cycle + 1;
    v  = cnt_at(64'hFFFF_FFFF_FFFF_FFFF, tb_s, tr);
    xfer("w.rlo", 1'b0, W_LO, 32'h0, 4'hF, v[31:0]);
    xfer("w.rhi", 1'b0, W_HI, 32'h0, 4'hF, v[63:32]);

    // Prescaler
    xfer("p.stop", 1'b1, W_CTRL, 32'h0, 4'hF, 32'h0);
    xfer("p.wlo",  1'b1, W_LO,   32'h0, 4'hF, 32'h0);
    xfer("p.whi",  1'b1, W_HI,   32'h0, 4'hF, 32'h0);
    tb_s = cycle + 1;
    xfer("p.en",   1'b1, W_CTRL, 32'h0000_0301, 4'hF, 32'h0);
`ifdef WB_MTIMER_PRESCALER_EN
    ctrl_exp = 32'h0000_0301;
`else
    ctrl_exp = 32'h0000_0001;
`endif
    xfer("p.ctrl", 1'b0, W_CTRL, 32'h0, 4'hF, ctrl_exp);
    tr = cycle + 1;
    v  = ps_at(tb_s, tr);
    xfer("p.r1", 1'b0, W_LO, 32'h0, 4'hF, v[31:0]);
    repeat (3) @(negedge clk);
    tr = cycle + 1;
    v  = ps_at(tb_s, tr);
    xfer("p.r2", 1'b0, W_LO, 32'h0, 4'hF, v[31:0]);
    repeat (2) @(negedge clk);
    tr = cycle + 1;
    v  = ps_at(tb_s, tr);
    xfer("p.r3", 1'b0, W_LO, 32'h0, 4'hF, v[31:0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_mtimer.md
Name: wb_mtimer

Overview:
- Wishbone classic (non-pipelined) slave timer, sitting directly downstream of the AXI-lite-to-Wishbone bridge; consumes its 32-bit Wishbone master port.
- Provides a 64-bit free-running mtime counter, a 64-bit mtimecmp compare register and a level timer interrupt to the core.
- Reading MTIME_LO latches a coherent MTIME_HI snapshot. This matches the bridge's 64-bit read, which issues the low word and then the high word as back-to-back Wishbone cycles.

Parameters:
- AW, 12, byte address width; Wishbone word address is [AW-1:2]; only bits [4:2] decoded, upper bits ignored (aliasing)

Ports:
- i_clk  input  1  clock
- i_rst  input  1  asynchronous active-high reset
- i_wb_adr  input  AW-2  word address [AW-1:2]
- i_wb_dat  input  32  write data
- i_wb_sel  input  4  byte enables
- i_wb_we  input  1  write enable
- i_wb_cyc  input  1  cycle
- i_wb_stb  input  1  strobe
- o_wb_rdt  output  32  read data
- o_wb_ack  output  1  transfer acknowledge
- o_wb_err  output  1  error (unmapped offset)
- o_irq  output  1  timer interrupt, level

Behaviour:
- Reset: async assert, sync release; all outputs 0 while i_rst high.
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, ctrl=0, hi_shadow=0, prescale count=0.
- Register map, byte offset ([4:2] of the word address):
  - 0x00 MTIME_LO rw
  - 0x04 MTIME_HI rw; reads return hi_shadow
  - 0x08 MTIMECMP_LO rw
  - 0x0C MTIMECMP_HI rw
  - 0x10 CTRL rw: [0] EN, [1] IRQ_EN, [15:8] PRE, others read 0
  - 0x14 STATUS ro: [0] PEND = (mtime >= mtimecmp), unsigned 64-bit compare
  - 0x18, 0x1C unmapped
- Handshake:
  - Request = i_wb_cyc & i_wb_stb & ~o_wb_ack & ~o_wb_err.
  - Response registered one cycle after the request: ack for mapped offsets, err for unmapped. Exactly one of ack/err, pulsed for 1 cycle.
  - The master holds stb until the response. The ~ack/~err term prevents a double response on the cycle stb is still high.
  - Request with cyc=0 or stb=0: ignored.
- Read path:
  - o_wb_rdt registered with the ack; holds its value until the next read response.
  - Unmapped read returns 0 with err.
  - Read of MTIME_LO also loads hi_shadow <= mtime[63:32], the value in the same cycle as the low word.
- Write path:
  - Byte-lane merge per i_wb_sel, committed on the request cycle (same edge that registers the ack).
  - sel=0 is a legal no-op write, still acked.
  - Writes to STATUS: acked, no effect.
  - Unmapped writes: err, no state change.
  - Any write to MTIME_LO/MTIME_HI suppresses that cycle's increment for all 64 bits; the written bytes win and unwritten bytes keep the pre-increment value.
- Counting:
  - mtime += 1 on each tick while EN=1.
  - Wraps 64'hFFFF_FFFF_FFFF_FFFF -> 0 with no flag.
- Interrupt:
  - o_irq registered: o_irq <= IRQ_EN & PEND, one cycle after mtime/mtimecmp/ctrl change.
  - Clearing is by writing mtimecmp above mtime, or IRQ_EN=0.
  - Partial mtimecmp updates (two 32-bit writes) may glitch o_irq; software writes MTIMECMP_HI=all-ones first.
- Reset mid-transaction: pending response dropped; no ack/err after reset deassertion unless a new request arrives.

Optional Feature:
- Macro: WB_MTIMER_PRESCALER_EN
- Defined:
  - Tick asserted once every PRE+1 cycles while EN=1, via an 8-bit down-counter reloaded from PRE.
  - Any CTRL write reloads the counter. EN=0 holds the counter at PRE.
  - PRE=0 gives one tick per cycle.
- Undefined:
  - Tick = EN every cycle.
  - CTRL[15:8] not stored, reads 0, writes ignored; no counter logic.

Test Plan:
- Reset, then read all map offsets -> MTIME 0/0, MTIMECMP FFFFFFFF/FFFFFFFF, CTRL 0, STATUS 0, o_irq 0; each read acked once, 1 cycle after stb.
- Write MTIME_LO=FFFF_FFFE, MTIME_HI=0, CTRL=1; wait 3 cycles; read LO then HI -> HI returns 1 (carry) coherently, even if the counter crosses a carry between the two reads.
- Write MTIMECMP_LO=0x20, MTIMECMP_HI=0, MTIME=0, CTRL=3 -> STATUS.PEND and o_irq rise when mtime reaches 0x20 (o_irq one cycle later); writing MTIMECMP_HI=1 drops o_irq next cycle.
- Write MTIME_LO with sel=4'b0010, data 0x0000_AB00, while counting -> only byte1 replaced, no increment that cycle; ack single pulse.
- Access offset 0x18, read and write -> o_wb_err 1 for 1 cycle, o_wb_ack 0, rdt 0, no state change; assert i_rst with a request outstanding -> no response after release.
- With WB_MTIMER_PRESCALER_EN: CTRL=0x0301 -> mtime increments every 4 cycles. Without the macro: same write -> increments every cycle, CTRL reads 0x0000_0001.
